// File: rtl/sarray_skew_buffer.sv
// Input-skew / output-deskew buffer for the systolic array edges: lane i leaves after its own delay.
// Optional macro SARRAY_SKEW_SIDEBAND_EN stores the sideband per stage; otherwise out_side_o is tied to 0.
module sarray_skew_buffer #(
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 32,
    parameter int SIDE_WIDTH = 8,
    parameter int BASE_DELAY = 1,
    parameter int DELAY_STEP = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode_i,
    input  logic                          hold_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    input  logic                          in_last_i,
    input  logic [SIDE_WIDTH-1:0]         in_side_i,
    input  logic [LANES*LANE_WIDTH-1:0]   in_data_i,
    output logic                          in_ready_o,
    output logic [LANES-1:0]              out_valid_o,
    output logic [LANES*SIDE_WIDTH-1:0]   out_side_o,
    output logic [LANES*LANE_WIDTH-1:0]   out_data_o,
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int D_MAX = BASE_DELAY + (LANES-1)*DELAY_STEP;
    localparam int IDX_W = (D_MAX > 1) ? $clog2(D_MAX) : 1;

    logic                  mode_r;
    logic                  accept;
    logic [D_MAX-1:0]      vld_p  [LANES];
    logic [D_MAX-1:0]      lst_p  [LANES];
    logic [LANE_WIDTH-1:0] data_p [LANES][D_MAX];
    logic [IDX_W-1:0]      tap_sel [LANES];
    logic                  long_vld;
    logic                  long_lst;

    function automatic logic [IDX_W-1:0] tap_of(input int lane, input logic deskew);
        int pos;
        pos = deskew ? (LANES-1-lane) : lane;
        return IDX_W'(BASE_DELAY + pos*DELAY_STEP - 1);
    endfunction

    assign in_ready_o = ~hold_i & ~flush_i;
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            tap_sel[l] = tap_of(l, mode_r);
        end
    end

    // Stage shift: flush beats hold, hold beats shift/accept
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                vld_p[l] <= '0;
                lst_p[l] <= '0;
                for (int k = 0; k < D_MAX; k++) begin
                    data_p[l][k] <= '0;
                end
            end
        end else begin
            if (flush_i) begin
                for (int l = 0; l < LANES; l++) begin
                    vld_p[l] <= '0;
                    lst_p[l] <= '0;
                end
            end else if (!hold_i) begin
                for (int l = 0; l < LANES; l++) begin
                    vld_p[l][0]  <= accept;
                    lst_p[l][0]  <= accept & in_last_i;
                    data_p[l][0] <= in_data_i[l*LANE_WIDTH +: LANE_WIDTH];
                    for (int k = 1; k < D_MAX; k++) begin
                        vld_p[l][k]  <= vld_p[l][k-1];
                        lst_p[l][k]  <= lst_p[l][k-1];
                        data_p[l][k] <= data_p[l][k-1];
                    end
                end
            end
            // Mode may only change with nothing in flight and nothing entering
            if (!busy_o && !accept) begin
                mode_r <= mode_i;
            end
        end
    end

`ifdef SARRAY_SKEW_SIDEBAND_EN
    logic [SIDE_WIDTH-1:0] side_p [LANES][D_MAX];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++) begin
                for (int k = 0; k < D_MAX; k++) begin
                    side_p[l][k] <= '0;
                end
            end
        end else if (!flush_i && !hold_i) begin
            for (int l = 0; l < LANES; l++) begin
                side_p[l][0] <= in_side_i;
                for (int k = 1; k < D_MAX; k++) begin
                    side_p[l][k] <= side_p[l][k-1];
                end
            end
        end
    end

    always_comb begin
        out_side_o = '0;
        for (int l = 0; l < LANES; l++) begin
            out_side_o[l*SIDE_WIDTH +: SIDE_WIDTH] = side_p[l][tap_sel[l]];
        end
    end
`else
    logic side_unused;
    assign side_unused = ^in_side_i;
    assign out_side_o  = '0;
`endif

    always_comb begin
        out_valid_o = '0;
        out_data_o  = '0;
        busy_o      = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            out_valid_o[l] = vld_p[l][tap_sel[l]];
            out_data_o[l*LANE_WIDTH +: LANE_WIDTH] = data_p[l][tap_sel[l]];
            for (int k = 0; k < D_MAX; k++) begin
                if (k <= int'(tap_sel[l])) begin
                    busy_o = busy_o | vld_p[l][k];
                end
            end
        end
    end

    // Only the longest lane's last beat marks the end of a tile
    always_comb begin
        long_vld = 1'b0;
        long_lst = 1'b0;
        if (mode_r) begin
            long_vld = vld_p[0][tap_sel[0]];
            long_lst = lst_p[0][tap_sel[0]];
        end else begin
            long_vld = vld_p[LANES-1][tap_sel[LANES-1]];
            long_lst = lst_p[LANES-1][tap_sel[LANES-1]];
        end
    end

    assign done_o = ~hold_i & long_vld & long_lst;

endmodule

// File: tb/tb_sarray_skew_buffer.sv
// Scoreboard bench for sarray_skew_buffer (4 lanes x 32 bits, base delay 1, step 1).
module tb_sarray_skew_buffer;
    localparam int LANES = 4;
    localparam int LW    = 32;
    localparam int SW    = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode_i, hold_i, flush_i, in_valid_i, in_last_i;
    logic [SW-1:0]      in_side_i;
    logic [LANES*LW-1:0] in_data_i;
    logic               in_ready_o;
    logic [LANES-1:0]   out_valid_o;
    logic [LANES*SW-1:0] out_side_o;
    logic [LANES*LW-1:0] out_data_o;
    logic               busy_o, done_o;

    sarray_skew_buffer #(
        .LANES(LANES), .LANE_WIDTH(LW), .SIDE_WIDTH(SW), .BASE_DELAY(1), .DELAY_STEP(1)
    ) dut (
        .clk(clk), .rst(rst), .mode_i(mode_i), .hold_i(hold_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_last_i(in_last_i), .in_side_i(in_side_i),
        .in_data_i(in_data_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
        .out_side_o(out_side_o), .out_data_o(out_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] data;
        logic [SW-1:0] side;
        int            cyc;
    } exp_t;

    exp_t lq [LANES][$];
    int   dq [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic tb_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < LANES; i++) lq[i].delete();
        dq.delete();
    endtask

    // Monitor: pops one entry each time a lane hands a beat onward
    always @(negedge clk) begin
        if (!rst) begin
            for (int l = 0; l < LANES; l++) begin
                if (out_valid_o[l] && !hold_i) begin
                    checks++;
                    if (lq[l].size() == 0) begin
                        errors++;
                        $display("FAIL lane%0d_unexpected: got data %0h at cycle %0d, required no beat",
                                 l, out_data_o[l*LW +: LW], cyc);
                    end else begin
                        exp_t e;
                        e = lq[l].pop_front();
                        if (out_data_o[l*LW +: LW] !== e.data || out_side_o[l*SW +: SW] !== e.side ||
                            (e.cyc >= 0 && e.cyc != cyc)) begin
                            errors++;
                            $display("FAIL lane%0d_beat: got data %0h side %0h cycle %0d, required data %0h side %0h cycle %0d",
                                     l, out_data_o[l*LW +: LW], out_side_o[l*SW +: SW], cyc, e.data, e.side, e.cyc);
                        end
                    end
                end
            end
            if (done_o) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
                end else begin
                    int d;
                    d = dq.pop_front();
                    if (d >= 0 && d != cyc) begin
                        errors++;
                        $display("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, d);
                    end
                end
            end
        end
    end

    // One cycle of stimulus; accepted beats push their expected lane outputs
    task automatic drive(input logic v, input logic l, input logic [LANES*LW-1:0] d,
                         input logic [SW-1:0] s, input logic h, input logic f, input logic m,
                         input bit chk_t, input int dcyc);
        logic [SW-1:0] es;
        in_valid_i = v; in_last_i = l; in_data_i = d; in_side_i = s;
        hold_i = h; flush_i = f; mode_i = m;
`ifdef SARRAY_SKEW_SIDEBAND_EN
        es = s;
`else
        es = '0;
`endif
        #1;
        chk("in_ready", {127'd0, in_ready_o}, {127'd0, ~h & ~f});
        if (v && !h && !f) begin
            for (int i = 0; i < LANES; i++) begin
                exp_t e;
                e.data = d[i*LW +: LW];
                e.side = es;
                e.cyc  = chk_t ? cyc + 1 + (tb_mode ? (LANES-1-i) : i) : -1;
                lq[i].push_back(e);
            end
            if (l) dq.push_back(dcyc);
        end
        @(posedge clk); #1;
        if (f) clear_q();
    endtask

    task automatic idle(input int n, input logic m);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, m, 1'b0, -1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        logic [LANES*LW-1:0] beat;
        rst = 1'b1; mode_i = 0; hold_i = 0; flush_i = 0;
        in_valid_i = 1; in_last_i = 1; in_side_i = 8'hFF; in_data_i = '1;
        @(posedge clk); #1;
        chk("rst_valid", {124'd0, out_valid_o}, 128'd0);
        chk("rst_data", out_data_o, 128'd0);
        chk("rst_side", {96'd0, out_side_o}, 128'd0);
        chk("rst_busy_done", {126'd0, busy_o, done_o}, 128'd0);
        rst = 1'b0;
        idle(1, 1'b0);

        // Skew single beat
        beat = 128'h00000044_00000033_00000022_00000011;
        base = cyc;
        drive(1, 1, beat, 8'hA5, 0, 0, 0, 1, base + 4);
        idle(3, 1'b0);
        chk("skew_busy_c4", {127'd0, busy_o}, 128'd1);
        idle(1, 1'b0);
        chk("skew_busy_c5", {127'd0, busy_o}, 128'd0);

        // Deskew: switch while idle, then same beat
        idle(1, 1'b1);
        tb_mode = 1'b1;
        base = cyc;
        drive(1, 1, beat, 8'hA5, 0, 0, 1, 1, base + 4);
        idle(6, 1'b1);

        // Stream of 8 beats with a 2-cycle stall in cycles 3-4
        idle(1, 1'b0);
        tb_mode = 1'b0;
        base = cyc;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            logic h;
            h = (c == 3 || c == 4);
            beat = {4{32'(k)}};
            drive(1, (k == 7), beat, 8'(8'h10 + k), h, 0, 0, 0, base + 13);
            if (!h) k++;
        end
        idle(8, 1'b0);

        // Flush in cycle 2 of a stream
        base = cyc;
        drive(1, 0, {4{32'hF0}}, 8'h01, 0, 0, 0, 1, -1);
        drive(1, 0, {4{32'hF1}}, 8'h02, 0, 0, 0, 1, -1);
        drive(1, 1, {4{32'hF2}}, 8'h03, 0, 1, 0, 1, -1);
        chk("flush_valid_c3", {124'd0, out_valid_o}, 128'd0);
        chk("flush_busy_c3", {127'd0, busy_o}, 128'd0);
        idle(4, 1'b0);

        // Mode toggled while busy is deferred until idle
        base = cyc;
        drive(1, 1, 128'h000000D4_000000D3_000000D2_000000D1, 8'h5A, 0, 0, 0, 1, base + 4);
        idle(3, 1'b1);
        chk("toggle_busy_c4", {127'd0, busy_o}, 128'd1);
        idle(2, 1'b1);
        tb_mode = 1'b1;
        base = cyc;
        drive(1, 1, 128'h000000E4_000000E3_000000E2_000000E1, 8'h6B, 0, 0, 1, 1, base + 4);
        idle(6, 1'b1);

        // Reset mid-stream
        idle(1, 1'b0);
        tb_mode = 1'b0;
        drive(1, 0, {4{32'h77}}, 8'hFF, 0, 0, 0, 1, -1);
        drive(1, 0, {4{32'h78}}, 8'hFF, 0, 0, 0, 1, -1);
        rst = 1'b1; in_valid_i = 1; in_last_i = 1; in_side_i = 8'hFF;
        @(posedge clk); #1;
        clear_q();
        chk("midrst_valid", {124'd0, out_valid_o}, 128'd0);
        chk("midrst_data", out_data_o, 128'd0);
        chk("midrst_side", {96'd0, out_side_o}, 128'd0);
        chk("midrst_busy_done", {126'd0, busy_o, done_o}, 128'd0);
        rst = 1'b0;
        idle(6, 1'b0);

        for (int i = 0; i < LANES; i++) chk("lane_queue_empty", 128'(lq[i].size()), 128'd0);
        chk("done_queue_empty", 128'(dq.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sarray_skew_buffer.md
# sarray_skew_buffer

Parametrised input-skew / output-deskew buffer for the systolic array. One input beat (LANES lanes of LANE_WIDTH data plus a shared sideband word) enters per cycle; lane i leaves after its own fixed delay, producing the diagonal wavefront the PE grid needs. The same block sits on the array's top and left edges (skew mode) and on the result edge (deskew mode). Unlike the earlier fixed shift registers, it supports:
- configurable base delay and step;
- run-time skew/deskew mode;
- global stall and flush;
- a busy flag and an end-of-tile done pulse.

## Interface
Parameters:
- LANES, 4, number of lanes (≥1)
- LANE_WIDTH, 32, data bits per lane
- SIDE_WIDTH, 8, sideband bits per beat (cnt/type/precision/acc packed by the caller)
- BASE_DELAY, 1, delay of the shortest lane in cycles (≥1)
- DELAY_STEP, 1, extra delay per lane position (≥0)

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- mode_i  in  1  0 = skew, 1 = deskew; sampled only when idle.
- hold_i  in  1  stall; freezes every pipeline stage.
- flush_i  in  1  discard all in-flight beats.
- in_valid_i  in  1  input beat valid.
- in_last_i  in  1  marks the final beat of a tile.
- in_side_i  in  SIDE_WIDTH  sideband, shared by all lanes.
- in_data_i  in  LANES*LANE_WIDTH  lane i at [i*LANE_WIDTH +: LANE_WIDTH].
- in_ready_o  out  1  beat accepted this cycle if in_valid_i is also high.
- out_valid_o  out  LANES  per-lane valid.
- out_side_o  out  LANES*SIDE_WIDTH  per-lane copy of the sideband.
- out_data_o  out  LANES*LANE_WIDTH  per-lane data.
- busy_o  out  1  any beat in flight.
- done_o  out  1  one-cycle pulse when the last beat leaves the longest lane.

## Operation
- Lane delays are set by the mode register mode_r:
  - skew (mode_r=0): D_i = BASE_DELAY + i*DELAY_STEP.
  - deskew (mode_r=1): D_i = BASE_DELAY + (LANES-1-i)*DELAY_STEP.
  - D_max = BASE_DELAY + (LANES-1)*DELAY_STEP.
- Storage: each lane has D_max physical stages. Each stage holds {valid, last, side, data}.
- Tap selection: the output of lane i is taken from stage D_i-1, chosen by mode_r. Stages beyond the tap are don't-care.
- Longest lane: lane LANES-1 in skew mode, lane 0 in deskew mode. Only this lane's last bit generates done_o; the other lanes carry it but never raise done_o.
- Accept rule: in_ready_o = !hold_i & !flush_i. A beat is accepted when in_valid_i & in_ready_o.
  - An accepted beat loads stage 0 of every lane with valid=1.
  - A non-accepted cycle with no hold loads a bubble (valid=0).
- Shift: when !hold_i, every stage k+1 takes stage k. When hold_i, all stages keep their value.
- Priority is flush > hold > shift/accept.
  - Flush clears every valid and last bit at the next edge. Data and side bits are left as they are.
- busy_o = OR of all valid bits in the tap-relevant stages.
- Mode update: mode_r takes mode_i on any edge where busy_o=0 and no beat is accepted that cycle. A mode_i change while busy is deferred until the buffer is idle.
- done_o = valid & last of the longest lane's output stage, gated by !hold_i. It is high for exactly one cycle per last beat, including while hold_i is released.

## Timing
- Reset, at the next clk edge with rst=1:
  - all stages cleared (valid, last, side, data = 0);
  - mode_r = 0;
  - out_valid_o = 0, out_side_o = 0, out_data_o = 0;
  - busy_o = 0, done_o = 0.
- in_ready_o depends only on inputs; it is 1 during reset if hold_i and flush_i are low, but inputs are ignored while rst=1.
- Latency: a beat accepted at edge t appears on lane i after edge t+D_i-1, i.e. it is visible during cycle t+D_i.
  - Hold cycles add one cycle each to the latency.
- Throughput: one beat per cycle; back-to-back beats stay contiguous on every lane.
- BASE_DELAY=1 with DELAY_STEP=0 gives a single-register pipe on every lane.
- Simultaneous events:
  - flush with in_valid_i: the beat is dropped.
  - hold and flush together: the flush applies.
  - Reset mid-tile: all in flight data is lost and no done_o is produced.
- An accepted beat with last=1 while another last beat is still in flight is legal; each produces its own done_o.

## Configuration
- Macro SARRAY_SKEW_SIDEBAND_EN.
  - Defined: the side field is stored per stage and out_side_o carries it.
  - Undefined: no side storage is built, in_side_i is ignored, and out_side_o is tied to 0.
- Valid, last and data behaviour is identical in both cases.

## Test plan
All scenarios use LANES=4, LANE_WIDTH=32, BASE_DELAY=1, DELAY_STEP=1, macro defined, unless stated otherwise.
- Skew, single beat 0x44,0x33,0x22,0x11 (lanes 3..0) with side 0xA5 and last=1, accepted at cycle 0:
  - lane 0 shows 0x11 in cycle 1, lane 1 shows 0x22 in cycle 2, lane 2 in cycle 3, lane 3 in cycle 4;
  - done_o pulses in cycle 4 only; every lane's side reads 0xA5;
  - busy_o falls after cycle 4.
- Deskew: set mode_i=1 while idle, then repeat the beat:
  - lane 3 appears in cycle 1 and lane 0 in cycle 4;
  - done_o pulses in cycle 4 on lane 0.
- Stream of 8 beats (data = beat index), last on beat 7, with hold_i high for cycles 3–4:
  - every lane outputs the indices 0..7 in order with no gap except the 2-cycle stall;
  - done_o pulses exactly once, 2 cycles later than in the unstalled run.
- Flush in cycle 2 of a 4-beat stream:
  - all out_valid_o are 0 from cycle 3 onward and no done_o occurs;
  - the flush-cycle beat is dropped (in_ready_o=0).
- Toggle mode_i while busy:
  - mode_r stays unchanged until busy_o=0, then updates;
  - lane timing of in-flight beats is unaffected.
- Reset asserted mid-stream:
  - all outputs are 0 at the next edge;
  - with the macro undefined, out_side_o stays 0 for side 0xFF.
